// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encoding and width default for the bit-serial adder
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int W_DEF = 8;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// rtl/serial_add_ctrl_fa.sv - combinational full-adder cell shared by every bit step
module serial_add_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequences one full-adder cell over W clocks to add two operands LSB first
import serial_add_ctrl_pkg::*;

module serial_add_ctrl #(
  parameter int W = W_DEF
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(W);

  state_t          state, state_n;
  logic [W-1:0]    sa, sb;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last;
  logic            fa_s, fa_co;

  serial_add_ctrl_fa fa_i (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt == CW'(W - 1));

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          state_n = RUN;
          accept  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // busy/done come from flops fed by next-state, so outputs never see a comb path from inputs
  always_ff @(posedge ck) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_n == RUN);
      done <= (state_n == DONE);
      if (accept) begin
        sa    <= a;
        sb    <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        sa    <= {1'b0, sa[W-1:1]};
        sb    <= {1'b0, sb[W-1:1]};
        sum   <= {fa_s, sum[W-1:1]};
        carry <= fa_co;
        cout  <= fa_co;
        // hold at W-1 on the final step so the counter never wraps
        if (!last) cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-shares a single full-adder cell to add two W-bit operands, one bit per clock, LSB first. It sits between a host register interface and the full-adder cell, trading area for latency in small standard-cell chips. It sequences operand shifting, carry storage, bit counting and result assembly behind a start/busy/done handshake.

## Interface
- W, default 8: operand width in bits, W >= 2.
- ck  input  1: clock; all state updates on rising edge.
- rst  input  1: reset, synchronous and active-high.
- start  input  1: request an addition; sampled only in IDLE or DONE.
- a  input  W: operand A, captured on the accepted start edge.
- b  input  W: operand B, captured on the accepted start edge.
- cin  input  1: carry-in, captured on the accepted start edge.
- busy  output  1: high while in RUN.
- done  output  1: one-cycle pulse, high in DONE.
- sum  output  W: result register. Valid from DONE until the next accepted start.
- cout  output  1: final carry. Valid with sum.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1:
  - load shift registers sa<=a and sb<=b;
  - set carry<=cin and cnt<=0;
  - go to RUN.
- RUN: each edge performs one bit step through the full-adder cell with inputs sa[0], sb[0], carry:
  - sa and sb shift right by 1, zero-filled;
  - cell sum bit shifts into sum from the MSB (sum <= {s, sum[W-1:1]});
  - carry <= cell co;
  - cnt++.
  - On the edge where cnt==W-1, perform the final step and go to DONE.
- DONE: done=1, busy=0. sum holds the full result and cout=carry.
  - start=1: accepted as in IDLE (back-to-back operation); go to RUN.
  - Otherwise go to IDLE.
- sum and cout hold their values in IDLE and DONE. They are overwritten only by RUN steps.
- sum reads partially shifted data while busy=1 and is undefined to the consumer during that time.
- start while busy=1 is ignored. No queuing, no effect on the in-flight operation.
- Arithmetic: {cout,sum} = a + b + cin, exact, modulo 2^(W+1). No overflow flag.
- cnt width is ceil(log2(W)) bits, range 0..W-1. It does not wrap while in RUN.
- rst=1 at any edge, including mid-RUN, forces the following state:
  - IDLE;
  - busy=0, done=0;
  - sum=0, cout=0;
  - sa=0, sb=0, carry=0, cnt=0.
  - The in-flight operation is discarded.
- rst has priority over start.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0.
- start accepted at edge k:
  - busy=1 after edge k through edge k+W;
  - W bit steps occur on edges k+1..k+W;
  - done=1 for the cycle after edge k+W.
- Latency: start edge to done high is W+1 cycles. Throughput is one addition per W+1 cycles with back-to-back start.
- done is exactly one cycle unless start is asserted during DONE. In that case busy rises on the next edge and done falls.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - default width constant W_DEF=8.
- One sub-module, fa: a pure combinational full-adder cell (a, b, ci -> s, co), instantiated once. All sequencing stays in serial_add_ctrl.

## Test plan
- Basic, W=8: a=0x3C, b=0x42, cin=0 -> done after 9 cycles, sum=0x7E, cout=0. busy high exactly 8 cycles.
- Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- Ignored start: pulse start with a=0x11 during RUN of 0x01+0x01 -> result sum=0x02, cout=0, single done pulse, no second operation.
- Back-to-back: hold start high through DONE with a=0x10, b=0x20 -> first result visible during DONE, second result sum=0x30 W+1 cycles later, busy low for exactly one cycle between the two operations.
- Reset mid-op: assert rst at step 4 of 0xF0+0x0F -> next cycle busy=0, done=0, sum=0x00, cout=0, state IDLE. A following start computes correctly.
- Exhaustive, W=2: all 32 (a,b,cin) combinations -> {cout,sum} equals a+b+cin for each.
